mem_stage_bw: RTL and testbench

Parametrised memory stage for the pipelined RV32I core. It replaces the word-only memory stage with the following:
- synchronous-read data RAM with byte, halfword and word loads/stores;
- sign and zero extension of load data;
- misalignment detection;
- the MEM/WB pipeline register, with stall and flush.

It sits between the EX/MEM register and the register-file write port, and produces the write-back data wD.

---
 rtl/mem_stage_bw_if.sv | 33 +++
 rtl/mem_stage_bw.sv | 147 ++++++++++++++
 tb/tb_mem_stage_bw.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_bw_if.sv
// Handshake/bus bundle between the EX/MEM register, the memory stage and write-back.
interface mem_stage_bw_if;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [31:0] alu;
  logic [31:0] rD2;
  logic        dram_we;
  logic        dram_re;
  logic [2:0]  funct3;
  logic [1:0]  wd_sel;
  logic [31:0] pc4;
  logic [4:0]  rd_idx;
  logic        rf_we;
  logic        wb_valid;
  logic        wb_rf_we;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wD;
  logic        misalign;
  logic [31:0] misalign_addr;

  modport master (
    output in_valid, stall, flush, alu, rD2, dram_we, dram_re,
           funct3, wd_sel, pc4, rd_idx, rf_we,
    input  wb_valid, wb_rf_we, wb_rd_idx, wD, misalign, misalign_addr
  );

  modport slave (
    input  in_valid, stall, flush, alu, rD2, dram_we, dram_re,
           funct3, wd_sel, pc4, rd_idx, rf_we,
    output wb_valid, wb_rf_we, wb_rd_idx, wD, misalign, misalign_addr
  );
endinterface

// File: rtl/mem_stage_bw.sv
// RV32I memory stage: byte-lane data RAM with synchronous read, load extension,
// misalignment detection and the MEM/WB pipeline register with stall/flush.
module mem_stage_bw #(
  parameter int DEPTH     = 4096,
  parameter int ADDR_W    = 12,
  parameter     INIT_FILE = ""
) (
  input logic           clk,
  input logic           rst,
  mem_stage_bw_if.slave bus
);

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic r;
    case (f3[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] r;
    case (f3[1:0])
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = off[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'd0, b} : 32'(b);
      2'b01:   r = f3[2] ? {16'd0, h} : 32'(h);
      default: r = word;
    endcase
    return r;
  endfunction

  logic [31:0] mem [DEPTH];

  // Stage p0: decode of the incoming EX/MEM instruction
  logic              acc_p0;
  logic              mis_p0;
  logic              wr_p0;
  logic [3:0]        be_p0;
  logic [31:0]       wdat_p0;
  logic [ADDR_W-1:0] idx_p0;

  always_comb begin
    acc_p0  = bus.in_valid & ~bus.stall & ~bus.flush;
    mis_p0  = (bus.dram_we | bus.dram_re) & is_misaligned(bus.funct3, bus.alu[1:0]);
    wr_p0   = acc_p0 & bus.dram_we & ~mis_p0 & ~rst;
    be_p0   = byte_en(bus.funct3, bus.alu[1:0]);
    wdat_p0 = store_lanes(bus.funct3, bus.rD2);
    idx_p0  = bus.alu[ADDR_W+1:2];
  end

  // Stage p1: RAM write commit and registered read port (read-before-write)
  logic [31:0] rdata_p1;

  always_ff @(posedge clk) begin
    if (wr_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p0[i]) mem[idx_p0][8*i +: 8] <= wdat_p0[8*i +: 8];
      end
    end
    if (!bus.stall) rdata_p1 <= mem[idx_p0];
  end

  logic        vld_p1;
  logic        rf_we_p1;
  logic [4:0]  rd_idx_p1;
  logic [31:0] alu_p1;
  logic [1:0]  wd_sel_p1;
  logic        mis_p1;
  logic [31:0] mis_addr_p1;
  logic [31:0] pc4_p1;
  logic [2:0]  funct3_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      rf_we_p1    <= 1'b0;
      rd_idx_p1   <= 5'd0;
      alu_p1      <= 32'd0;
      wd_sel_p1   <= 2'b00;
      mis_p1      <= 1'b0;
      mis_addr_p1 <= 32'd0;
    end else begin
      mis_p1 <= acc_p0 & mis_p0;
      if (acc_p0 & mis_p0) mis_addr_p1 <= bus.alu;
      if (acc_p0) begin
        vld_p1    <= 1'b1;
        rf_we_p1  <= bus.rf_we & ~mis_p0;
        rd_idx_p1 <= bus.rd_idx;
        alu_p1    <= bus.alu;
        wd_sel_p1 <= bus.wd_sel;
      end else if (!bus.stall) begin
        vld_p1   <= 1'b0;
        rf_we_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      pc4_p1    <= bus.pc4;
      funct3_p1 <= bus.funct3;
    end
  end

  // Write-back mux from registered fields
  always_comb begin
    case (wd_sel_p1)
      2'b00:   bus.wD = alu_p1;
      2'b01:   bus.wD = load_ext(rdata_p1, funct3_p1, alu_p1[1:0]);
      2'b10:   bus.wD = pc4_p1;
      default: bus.wD = 32'd0;
    endcase
  end

  assign bus.wb_valid      = vld_p1;
  assign bus.wb_rf_we      = rf_we_p1;
  assign bus.wb_rd_idx     = rd_idx_p1;
  assign bus.misalign      = mis_p1;
  assign bus.misalign_addr = mis_addr_p1;

endmodule

// File: tb/tb_mem_stage_bw.sv
// Randomized bench for mem_stage_bw against a byte-array reference model.
module tb_mem_stage_bw;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int BYTES = 4 * DEPTH;
  localparam logic [31:0] MSK = 32'(BYTES - 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_bw_if bus ();

  mem_stage_bw #(.DEPTH(DEPTH), .ADDR_W(AW), .INIT_FILE("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0]  mb [BYTES];
  logic        e_v, e_rfwe, e_mis;
  logic [4:0]  e_rd;
  logic [31:0] e_wd, e_maddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] f3);
    int b;
    logic [15:0] h;
    logic [31:0] v;
    if (f3[1:0] == 2'b00) begin
      b = int'(a & MSK);
      v = f3[2] ? {24'd0, mb[b]} : {{24{mb[b][7]}}, mb[b]};
    end else if (f3[1:0] == 2'b01) begin
      b = int'(a & MSK & ~32'd1);
      h = {mb[b+1], mb[b]};
      v = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
    end else begin
      b = int'(a & MSK & ~32'd3);
      v = {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    end
    return v;
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    int b;
    if (f3[1:0] == 2'b00) begin
      mb[int'(a & MSK)] = d[7:0];
    end else if (f3[1:0] == 2'b01) begin
      b = int'(a & MSK & ~32'd1);
      mb[b] = d[7:0]; mb[b+1] = d[15:8];
    end else begin
      b = int'(a & MSK & ~32'd3);
      mb[b] = d[7:0]; mb[b+1] = d[15:8]; mb[b+2] = d[23:16]; mb[b+3] = d[31:24];
    end
  endtask

  // One clock cycle: drive, advance the model at the edge, check outputs 1 ns later.
  task automatic cyc(input logic v, input logic st, input logic fl, input logic we,
                     input logic re, input logic [2:0] f3, input logic [1:0] ws,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                     input logic [4:0] rd, input logic rfw, input logic r);
    logic acc, mis;
    bus.in_valid = v;  bus.stall = st;  bus.flush = fl;
    bus.dram_we = we;  bus.dram_re = re; bus.funct3 = f3;
    bus.wd_sel = ws;   bus.alu = a;      bus.rD2 = d;
    bus.pc4 = p;       bus.rd_idx = rd;  bus.rf_we = rfw;
    rst = r;
    @(posedge clk);
    if (r) begin
      e_v = 0; e_rfwe = 0; e_rd = 0; e_mis = 0; e_maddr = 0; e_wd = 0;
    end else begin
      mis = (we | re) && ((f3[1:0] == 2'b01 && a[0]) || (f3[1] && a[1:0] != 2'b00));
      acc = v & ~st & ~fl;
      e_mis = acc & mis;
      if (acc) begin
        if (mis) e_maddr = a;
        e_v = 1; e_rfwe = rfw & ~mis; e_rd = rd;
        case (ws)
          2'b00: e_wd = a;
          2'b01: e_wd = mdl_load(a, f3);
          2'b10: e_wd = p;
          default: e_wd = 32'd0;
        endcase
        if (we && !mis) mdl_store(a, f3, d);
      end else if (!st) begin
        e_v = 0; e_rfwe = 0;
      end
    end
    #1;
    chk("wb_valid", {31'd0, bus.wb_valid}, {31'd0, e_v});
    chk("wb_rf_we", {31'd0, bus.wb_rf_we}, {31'd0, e_rfwe});
    chk("misalign", {31'd0, bus.misalign}, {31'd0, e_mis});
    chk("misalign_addr", bus.misalign_addr, e_maddr);
    if (r) begin
      chk("wb_rd_idx_rst", {27'd0, bus.wb_rd_idx}, 32'd0);
      chk("wD_rst", bus.wD, 32'd0);
    end
    if (e_v) begin
      chk("wb_rd_idx", {27'd0, bus.wb_rd_idx}, {27'd0, e_rd});
      chk("wD", bus.wD, e_wd);
    end
  endtask

  task automatic st_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    cyc(1, 0, 0, 1, 0, f3, 2'b00, a, d, 32'h4, 5'd3, 1'b0, 1'b0);
  endtask

  task automatic ld_op(input logic [2:0] f3, input logic [31:0] a);
    cyc(1, 0, 0, 0, 1, f3, 2'b01, a, 32'h0, 32'h8, 5'd7, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic v, st, fl, we, re, rfw, r;
    logic [31:0] a;
    for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;

    // Reset state
    cyc(0, 0, 0, 0, 0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    cyc(1, 0, 0, 1, 0, 3'b010, 2'b01, 32'h10, 32'h1234, 32'h0, 5'd9, 1'b1, 1'b1);
    idle();
    chk("wD_after_rst", bus.wD, 32'd0);

    // Give every RAM word a known value
    for (int i = 0; i < DEPTH; i++) st_op(3'b010, 32'(i * 4), $urandom);

    // Word round trip
    st_op(3'b010, 32'h100, 32'hDEADBEEF);
    ld_op(3'b010, 32'h100);
    chk("rt_word", bus.wD, 32'hDEADBEEF);
    chk("rt_rfwe", {31'd0, bus.wb_rf_we}, 32'd1);

    // Byte/half lanes
    st_op(3'b010, 32'h200, 32'h11223344);
    st_op(3'b000, 32'h203, 32'h00000080);
    ld_op(3'b010, 32'h200); chk("lane_lw", bus.wD, 32'h80223344);
    ld_op(3'b000, 32'h203); chk("lane_lb", bus.wD, 32'hFFFFFF80);
    ld_op(3'b100, 32'h203); chk("lane_lbu", bus.wD, 32'h00000080);
    ld_op(3'b001, 32'h202); chk("lane_lh", bus.wD, 32'hFFFF8022);

    // Misaligned accesses
    st_op(3'b010, 32'h102, 32'h55555555);
    chk("mis_pulse", {31'd0, bus.misalign}, 32'd1);
    chk("mis_addr", bus.misalign_addr, 32'h102);
    idle();
    chk("mis_drop", {31'd0, bus.misalign}, 32'd0);
    ld_op(3'b010, 32'h100); chk("mis_nowrite", bus.wD, 32'hDEADBEEF);
    ld_op(3'b001, 32'h101); chk("mis_lh_rfwe", {31'd0, bus.wb_rf_we}, 32'd0);

    // Stall: held load result, store presented during stall lands once
    ld_op(3'b010, 32'h100);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 1, 0, 3'b010, 2'b00, 32'h300, 32'hCAFEF00D, 32'h0, 5'd4, 1'b0, 1'b0);
      chk("stall_wd", bus.wD, 32'hDEADBEEF);
      chk("stall_rd", {27'd0, bus.wb_rd_idx}, 32'd7);
    end
    st_op(3'b010, 32'h300, 32'hCAFEF00D);
    ld_op(3'b010, 32'h300); chk("stall_store", bus.wD, 32'hCAFEF00D);

    // Flush, and flush under stall
    cyc(1, 0, 1, 1, 0, 3'b000, 2'b00, 32'h200, 32'h55, 32'h0, 5'd2, 1'b1, 1'b0);
    chk("flush_vld", {31'd0, bus.wb_valid}, 32'd0);
    ld_op(3'b010, 32'h200); chk("flush_mem", bus.wD, 32'h80223344);
    cyc(1, 1, 1, 1, 0, 3'b000, 2'b00, 32'h200, 32'h55, 32'h0, 5'd2, 1'b1, 1'b0);
    chk("flush_stall_hold", {31'd0, bus.wb_valid}, 32'd1);
    cyc(1, 0, 1, 1, 0, 3'b000, 2'b00, 32'h200, 32'h55, 32'h0, 5'd2, 1'b1, 1'b0);
    chk("flush_release", {31'd0, bus.wb_valid}, 32'd0);

    // Write-back mux and address wrap
    cyc(1, 0, 0, 0, 0, 3'b000, 2'b10, 32'h1234, 32'h0, 32'h44, 5'd1, 1'b1, 1'b0);
    chk("jal_pc4", bus.wD, 32'h44);
    st_op(3'b010, 32'(BYTES + 8), 32'hA5A50F0F);
    ld_op(3'b010, 32'h8); chk("wrap", bus.wD, 32'hA5A50F0F);

    // Mid-stream reset suppresses the in-flight store
    cyc(1, 0, 0, 1, 0, 3'b010, 2'b00, 32'h8, 32'h0BADF00D, 32'h0, 5'd5, 1'b1, 1'b1);
    ld_op(3'b010, 32'h8); chk("rst_nostore", bus.wD, 32'hA5A50F0F);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      v   = ($urandom_range(0, 99) < 85);
      st  = ($urandom_range(0, 99) < 20);
      fl  = ($urandom_range(0, 99) < 10);
      r   = ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 2))
        0: begin we = 1; re = 0; end
        1: begin we = 0; re = 1; end
        default: begin we = 0; re = 0; end
      endcase
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << 10);
      rfw = $urandom_range(0, 1);
      cyc(v, st, fl, we, re, 3'($urandom), re ? 2'b01 : 2'($urandom), a, $urandom,
          $urandom, 5'($urandom), rfw, r);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
